// File: rtl/tomasulo_regstat_if.sv
// tomasulo_regstat_if: bus between issue/CDB logic (master) and the register-status file (slave)
// Carries operand read ports, destination allocation, CDB broadcasts, flush, pending count and error flag.
interface tomasulo_regstat_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int TAGW = 5,
  parameter int NCDB = 2,
  parameter int NRP  = 2
);
  localparam int AW = $clog2(NREG);
  logic [NRP*AW-1:0]    rd_addr;
  logic [NRP*XLEN-1:0]  rd_data;
  logic [NRP*TAGW-1:0]  rd_tag;
  logic [NRP-1:0]       rd_ready;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_addr;
  logic [TAGW-1:0]      alloc_tag;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*TAGW-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0] cdb_data;
  logic                 flush;
  logic [AW:0]          pending_cnt;
  logic                 err;
  modport master (
    output rd_addr, alloc_en, alloc_addr, alloc_tag, cdb_valid, cdb_tag, cdb_data, flush,
    input  rd_data, rd_tag, rd_ready, pending_cnt, err
  );
  modport slave (
    input  rd_addr, alloc_en, alloc_addr, alloc_tag, cdb_valid, cdb_tag, cdb_data, flush,
    output rd_data, rd_tag, rd_ready, pending_cnt, err
  );
endinterface

// File: rtl/tomasulo_regstat.sv
// tomasulo_regstat: Tomasulo register-status file with multi-channel CDB capture, read bypass, flush and pending count
// Ports: clk; nRST (async, active-low); bus (slave): rd_addr/rd_data/rd_tag/rd_ready read ports,
// alloc_en/alloc_addr/alloc_tag rename, cdb_valid/cdb_tag/cdb_data broadcasts, flush, pending_cnt, err.
module tomasulo_regstat #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int TAGW = 5,
  parameter int NCDB = 2,
  parameter int NRP  = 2
) (
  input logic clk,
  input logic nRST,
  tomasulo_regstat_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] regData [NREG];
  logic [TAGW-1:0] regTag [NREG];
  logic [XLEN-1:0] capData [NREG];
  logic [XLEN-1:0] nextData [NREG];
  logic [TAGW-1:0] nextTag [NREG];
  logic [NREG-1:0] capHit;
  logic [NREG-1:0] allocHit;
  logic [AW:0]     nextCnt;
  logic [AW:0]     pendingCnt;
  logic            dupTag;
  logic            badAlloc;
  logic            errQ;
  // Scan channels high-to-low so the lowest matching channel is the one that sticks.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      capHit[i] = 1'b0;
      capData[i] = '0;
      for (int k = NCDB - 1; k >= 0; k--)
        if (bus.cdb_valid[k] && regTag[i] != '0 && bus.cdb_tag[k*TAGW +: TAGW] == regTag[i]) begin
          capHit[i] = 1'b1;
          capData[i] = bus.cdb_data[k*XLEN +: XLEN];
        end
    end
  end
  // Allocation wins over a same-cycle tag clear; flush clears everything and drops the allocation.
  always_comb begin
    nextCnt = '0;
    for (int i = 0; i < NREG; i++) begin
      allocHit[i] = i != 0 && bus.alloc_en && !bus.flush && bus.alloc_addr == AW'(i) && bus.alloc_tag != '0;
      nextData[i] = i == 0 ? '0 : capHit[i] ? capData[i] : regData[i];
      nextTag[i] = (i == 0 || bus.flush) ? '0 : allocHit[i] ? bus.alloc_tag : capHit[i] ? '0 : regTag[i];
      nextCnt = nextCnt + (AW+1)'(nextTag[i] != '0);
    end
  end
  always_comb begin
    dupTag = 1'b0;
    for (int k = 0; k < NCDB; k++)
      for (int j = k + 1; j < NCDB; j++)
        if (bus.cdb_valid[k] && bus.cdb_valid[j] && bus.cdb_tag[k*TAGW +: TAGW] != '0 &&
            bus.cdb_tag[k*TAGW +: TAGW] == bus.cdb_tag[j*TAGW +: TAGW])
          dupTag = 1'b1;
    badAlloc = bus.alloc_en && !bus.flush && bus.alloc_addr != '0 && bus.alloc_tag == '0;
  end
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      for (int i = 0; i < NREG; i++) begin
        regData[i] <= '0;
        regTag[i] <= '0;
      end
      pendingCnt <= '0;
      errQ <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regData[i] <= nextData[i];
        regTag[i] <= nextTag[i];
      end
      pendingCnt <= nextCnt;
      errQ <= errQ | dupTag | badAlloc;
    end
  // capHit already encodes "stored tag nonzero and broadcast this cycle", so it doubles as the bypass select.
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.rd_addr[p*AW +: AW];
    assign bus.rd_data[p*XLEN +: XLEN] = capHit[a] ? capData[a] : regData[a];
    assign bus.rd_tag[p*TAGW +: TAGW] = capHit[a] ? '0 : regTag[a];
    assign bus.rd_ready[p] = capHit[a] || regTag[a] == '0;
  end
  assign bus.pending_cnt = pendingCnt;
  assign bus.err = errQ;
endmodule

// File: tb/tb_tomasulo_regstat.sv
// tb_tomasulo_regstat: directed checks of capture, bypass, WAW, flush, error and reset behaviour
module tb_tomasulo_regstat;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  tomasulo_regstat_if bus ();
  tomasulo_regstat dut (.clk(clk), .nRST(nRST), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.alloc_en = 1'b0;
    bus.alloc_addr = '0;
    bus.alloc_tag = '0;
    bus.cdb_valid = '0;
    bus.cdb_tag = '0;
    bus.cdb_data = '0;
    bus.flush = 1'b0;
  endtask
  task automatic rd(input int a, input int b);
    bus.rd_addr = {5'(b), 5'(a)};
  endtask
  task automatic alloc(input int a, input int t);
    bus.alloc_en = 1'b1;
    bus.alloc_addr = 5'(a);
    bus.alloc_tag = 5'(t);
  endtask
  task automatic cdb(input int k, input logic [4:0] t, input logic [31:0] d);
    bus.cdb_valid[k] = 1'b1;
    bus.cdb_tag[k*5 +: 5] = t;
    bus.cdb_data[k*32 +: 32] = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask
  initial begin
    idle();
    rd(5, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d0", 64'(bus.rd_data[31:0]), 64'h0);
    chk("rst_d1", 64'(bus.rd_data[63:32]), 64'h0);
    chk("rst_tag", 64'(bus.rd_tag), 64'h0);
    chk("rst_rdy", 64'(bus.rd_ready), 64'h3);
    chk("rst_cnt", 64'(bus.pending_cnt), 64'h0);
    chk("rst_err", 64'(bus.err), 64'h0);
    nRST = 1'b1;
    alloc(0, 5);
    step();
    chk("r0_alloc_cnt", 64'(bus.pending_cnt), 64'h0);
    chk("r0_alloc_tag", 64'(bus.rd_tag[9:5]), 64'h0);
    alloc(3, 7);
    rd(3, 0);
    step();
    chk("a3_cnt", 64'(bus.pending_cnt), 64'd1);
    chk("a3_tag", 64'(bus.rd_tag[4:0]), 64'd7);
    chk("a3_rdy", 64'(bus.rd_ready[0]), 64'd0);
    cdb(1, 5'd7, 32'hDEADBEEF);
    #1;
    chk("byp_data", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
    chk("byp_tag", 64'(bus.rd_tag[4:0]), 64'h0);
    chk("byp_rdy", 64'(bus.rd_ready[0]), 64'd1);
    step();
    chk("cap_data", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
    chk("cap_cnt", 64'(bus.pending_cnt), 64'd0);
    alloc(4, 2);
    step();
    alloc(6, 2);
    step();
    chk("dup_cnt2", 64'(bus.pending_cnt), 64'd2);
    rd(4, 6);
    cdb(0, 5'd2, 32'h11);
    cdb(1, 5'd2, 32'h22);
    #1;
    chk("dup_byp4", 64'(bus.rd_data[31:0]), 64'h11);
    chk("dup_byp6", 64'(bus.rd_data[63:32]), 64'h11);
    chk("dup_err_pre", 64'(bus.err), 64'd0);
    step();
    chk("dup_cap4", 64'(bus.rd_data[31:0]), 64'h11);
    chk("dup_cap6", 64'(bus.rd_data[63:32]), 64'h11);
    chk("dup_err", 64'(bus.err), 64'd1);
    chk("dup_cnt0", 64'(bus.pending_cnt), 64'd0);
    step();
    chk("err_sticky", 64'(bus.err), 64'd1);
    alloc(8, 3);
    step();
    alloc(8, 9);
    rd(8, 0);
    step();
    chk("waw_tag", 64'(bus.rd_tag[4:0]), 64'd9);
    chk("waw_cnt", 64'(bus.pending_cnt), 64'd1);
    cdb(0, 5'd3, 32'h55);
    #1;
    chk("waw_nobyp", 64'(bus.rd_data[31:0]), 64'h0);
    step();
    chk("waw_old_data", 64'(bus.rd_data[31:0]), 64'h0);
    chk("waw_old_tag", 64'(bus.rd_tag[4:0]), 64'd9);
    cdb(0, 5'd9, 32'h66);
    step();
    chk("waw_new_data", 64'(bus.rd_data[31:0]), 64'h66);
    chk("waw_new_rdy", 64'(bus.rd_ready[0]), 64'd1);
    chk("waw_cnt0", 64'(bus.pending_cnt), 64'd0);
    alloc(10, 4);
    rd(10, 0);
    step();
    chk("se_cnt_pre", 64'(bus.pending_cnt), 64'd1);
    cdb(0, 5'd4, 32'hAA);
    alloc(10, 12);
    #1;
    chk("se_byp_data", 64'(bus.rd_data[31:0]), 64'hAA);
    chk("se_byp_tag", 64'(bus.rd_tag[4:0]), 64'd0);
    step();
    chk("se_data", 64'(bus.rd_data[31:0]), 64'hAA);
    chk("se_tag", 64'(bus.rd_tag[4:0]), 64'd12);
    chk("se_cnt", 64'(bus.pending_cnt), 64'd1);
    for (int r = 11; r <= 14; r++) begin
      alloc(r, r + 2);
      step();
    end
    chk("fl_cnt5", 64'(bus.pending_cnt), 64'd5);
    bus.flush = 1'b1;
    alloc(2, 1);
    rd(10, 2);
    step();
    chk("fl_cnt", 64'(bus.pending_cnt), 64'd0);
    chk("fl_data", 64'(bus.rd_data[31:0]), 64'hAA);
    chk("fl_tags", 64'(bus.rd_tag), 64'h0);
    chk("fl_rdy", 64'(bus.rd_ready), 64'h3);
    step();
    chk("fl_cnt_hold", 64'(bus.pending_cnt), 64'd0);
    alloc(5, 6);
    rd(10, 5);
    step();
    chk("mr_tag", 64'(bus.rd_tag[9:5]), 64'd6);
    nRST = 1'b0;
    #1;
    chk("mr_data", 64'(bus.rd_data[31:0]), 64'h0);
    chk("mr_cnt", 64'(bus.pending_cnt), 64'h0);
    chk("mr_err", 64'(bus.err), 64'h0);
    chk("mr_tag0", 64'(bus.rd_tag[9:5]), 64'h0);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    cdb(0, 5'd6, 32'h77);
    step();
    chk("mr_ignore", 64'(bus.rd_data[63:32]), 64'h0);
    chk("mr_cnt_after", 64'(bus.pending_cnt), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tomasulo_regstat.md
# tomasulo_regstat

Parametrised register-status file for the Tomasulo issue stage. It holds architectural register values together with a producer tag per register. It captures results from several common-data-bus (CDB) channels in the same cycle and bypasses same-cycle broadcasts to its read ports. It supports a global flush of all pending tags and keeps a live count of renamed registers. It sits between decode/issue, which reads operands and allocates destination tags, and the CDB arbiter, which broadcasts completed results.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers; register 0 is hardwired zero
- TAGW, 5, producer tag width; tag 0 means "value ready, no producer"
- NCDB, 2, number of CDB broadcast channels
- NRP, 2, number of operand read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous, active-low
- rd_addr  in  NRP*clog2(NREG)  read addresses, port p at slice p
- rd_data  out  NRP*XLEN  operand value per port
- rd_tag  out  NRP*TAGW  producer tag per port; 0 when ready
- rd_ready  out  NRP  1 when rd_tag is 0
- alloc_en  in  1  rename destination this cycle
- alloc_addr  in  clog2(NREG)  destination register
- alloc_tag  in  TAGW  new producer tag; must be nonzero
- cdb_valid  in  NCDB  broadcast valid per channel
- cdb_tag  in  NCDB*TAGW  broadcast tag per channel
- cdb_data  in  NCDB*XLEN  broadcast result per channel
- flush  in  1  clear all pending tags (mispredict recovery)
- pending_cnt  out  clog2(NREG)+1  registered count of registers with a nonzero tag
- err  out  1  sticky protocol-error flag

## Operation
- Per-register state: data[XLEN], tag[TAGW]. Register 0 always reads data 0, tag 0. Writes and allocations to register 0 are ignored.
- Capture, per register i≠0, per rising edge:
  - If tag[i]≠0 and some channel k has cdb_valid[k] and cdb_tag[k]==tag[i], then data[i] ← cdb_data[k] and tag[i] ← 0.
  - If multiple channels match, the lowest k wins.
  - Several registers may capture from the same channel in the same cycle.
- Allocation:
  - If alloc_en, alloc_addr==i≠0 and alloc_tag≠0, then tag[i] ← alloc_tag. This overrides any same-cycle tag clear from capture.
  - A same-cycle capture still writes data[i].
  - Re-allocating a register that already has a pending tag (WAW) is legal. The newest tag replaces the old one, and a later broadcast of the old tag no longer updates that register. There is no stall.
- Flush:
  - All tags ← 0.
  - CDB data capture for registers matching in the flush cycle still occurs.
  - alloc_en is ignored in the flush cycle.
  - Data values are otherwise unchanged.
- Read ports (combinational):
  - rd_data and rd_tag reflect the stored state.
  - Bypass: if the stored tag≠0 and matches a valid CDB channel this cycle (lowest k wins), the port returns that cdb_data with rd_tag 0 and rd_ready 1.
  - A same-cycle allocation is not visible on read ports. An instruction reading its own destination sees the pre-rename mapping.
- pending_cnt equals the number of registers 1..NREG-1 with nonzero tag after the edge. It is recomputed from next-state every cycle and registered.
- err is set and held until reset on either condition:
  - two valid CDB channels carry the same nonzero tag in one cycle;
  - alloc_en with alloc_addr≠0 and alloc_tag==0 (that allocation is dropped).

## Timing
- Reset (nRST low, asynchronous): all data 0, all tags 0, pending_cnt 0, err 0. Read outputs follow immediately: rd_data 0, rd_tag 0, rd_ready all 1.
- Reset asserted mid-operation discards all pending tags and data. Broadcasts arriving in the first edge after release find tag 0 and are ignored.
- Capture latency: a broadcast in cycle N is visible from stored state in cycle N+1. Through the bypass it is visible on reads in cycle N, with zero added latency.
- Allocation latency: a tag allocated in cycle N appears on read ports from cycle N+1.
- pending_cnt and err update one edge after the causing event.
- Zero-cycle paths: rd_addr/cdb_* to rd_* only. No combinational path from alloc_* or flush to any output.

## Test plan
- Reset, then read r5 and r0 → data 0, tag 0, ready 1. pending_cnt 0, err 0.
- Alloc r3 tag 7. Next cycle broadcast ch1 tag 7 data 0xDEADBEEF → read of r3 in the broadcast cycle returns 0xDEADBEEF, ready 1 (bypass). Next cycle the stored value is the same. pending_cnt goes 1 then 0.
- Alloc r4 tag 2 and r6 tag 2 (illegal but stored); ch0 tag 2 data 0x11 → both r4 and r6 capture 0x11. Same cycle ch1 tag 2 → err sets and stays 1.
- WAW: alloc r8 tag 3, then alloc r8 tag 9, then broadcast tag 3 data 0x55 → r8 data unchanged, tag stays 9. Broadcast tag 9 data 0x66 → r8 = 0x66, ready.
- Same edge: broadcast tag 4 data 0xAA while alloc r10 tag 12, where r10 previously had tag 4 → r10 data 0xAA, tag 12, pending_cnt unchanged.
- Five registers pending, then assert flush with alloc_en r2 tag 1 → all tags 0, r2 not renamed, pending_cnt 0 next cycle, data preserved.
